// File: rtl/lsu_misaligned_unit_pkg.sv
// Shared definitions for the load/store unit: funct3 codes,
// FSM state encoding and access-size decode.
package lsu_misaligned_unit_pkg;

    localparam logic [2:0] FNC_LB  = 3'b000;
    localparam logic [2:0] FNC_LH  = 3'b001;
    localparam logic [2:0] FNC_LW  = 3'b010;
    localparam logic [2:0] FNC_LD  = 3'b011;
    localparam logic [2:0] FNC_LBU = 3'b100;
    localparam logic [2:0] FNC_LHU = 3'b101;
    localparam logic [2:0] FNC_LWU = 3'b110;

    localparam logic [2:0] FNC_SB  = 3'b000;
    localparam logic [2:0] FNC_SH  = 3'b001;
    localparam logic [2:0] FNC_SW  = 3'b010;
    localparam logic [2:0] FNC_SD  = 3'b011;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BEAT0,
        ST_BEAT1,
        ST_CAPTURE,
        ST_RESP
    } state_t;

    function automatic int nb_of(input int xlen);
        return xlen / 8;
    endfunction

    // Encodings wider than the datapath collapse to a full-word access.
    function automatic logic [3:0] size_bytes(input logic [2:0] f3,
                                              input int nb);
        logic [3:0] s;
        s = 4'd1 << f3[1:0];
        if (f3 == 3'b111)
            s = 4'(nb);
        else if (nb == 4 && (f3 == FNC_LD || f3 == FNC_LWU))
            s = 4'd4;
        return s;
    endfunction

endpackage

// File: rtl/lsu_misaligned_unit_load_align.sv
// Extracts and extends a load result from a two-word window.
// Purely combinational.
module lsu_load_align
    import lsu_misaligned_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2*XLEN-1:0]         data,
    input  logic [$clog2(XLEN/8)-1:0] off,
    input  logic [2:0]                funct3,
    output logic [XLEN-1:0]           result
);

    localparam int NB = nb_of(XLEN);

    logic [3:0]      size;
    logic [XLEN-1:0] low;
    logic [XLEN-1:0] mask;
    logic [XLEN-1:0] top;
    logic [XLEN-1:0] field;
    logic            sign;

    // A full-width mask falls out of the shift overflowing to zero.
    always_comb begin
        size   = size_bytes(funct3, NB);
        low    = XLEN'(data >> {off, 3'b000});
        mask   = (XLEN'(1) << {size, 3'b000}) - XLEN'(1);
        top    = mask & ~(mask >> 1);
        field  = low & mask;
        sign   = (|(low & top)) & ~funct3[2];
        result = sign ? (field | ~mask) : field;
    end

endmodule

// File: rtl/lsu_misaligned_unit.sv
// Multi-cycle load/store unit with optional two-beat handling
// of word-spanning accesses.
module lsu_misaligned_unit
    import lsu_misaligned_unit_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter bit MISALIGN_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_store,
    input  logic [2:0]        req_funct3,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              mem_en,
    output logic [XLEN/8-1:0] mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [XLEN-1:0]   resp_data,
    output logic              resp_misaligned
);

    localparam int NB  = nb_of(XLEN);
    localparam int NB2 = 2 * NB;
    localparam int OW  = $clog2(NB);

    state_t state_q, state_d;

    logic            is_store_q;
    logic [2:0]      funct3_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] beat0_q;

    logic [3:0]        in_size;
    logic              in_misaligned;
    logic              reject;
    logic              accept;
    logic [3:0]        size_q;
    logic [OW-1:0]     off_q;
    logic              spans_q;
    logic [XLEN-1:0]   base_q;
    logic [NB2-1:0]    we_full;
    logic [2*XLEN-1:0] wd_full;
    logic [2*XLEN-1:0] align_in;
    logic [XLEN-1:0]   align_out;

    always_comb begin
        in_size       = size_bytes(req_funct3, NB);
        in_misaligned = (req_addr[OW-1:0] & OW'(in_size - 4'd1)) != '0;
        reject        = in_misaligned && !MISALIGN_EN;
        accept        = req_valid && (state_q == ST_IDLE);
        size_q        = size_bytes(funct3_q, NB);
        off_q         = addr_q[OW-1:0];
        spans_q       = (int'(off_q) + int'(size_q)) > NB;
        base_q        = {addr_q[XLEN-1:OW], {OW{1'b0}}};
        we_full       = ((NB2'(1) << size_q) - NB2'(1)) << off_q;
        wd_full       = {{XLEN{1'b0}}, wdata_q} << {off_q, 3'b000};
        // Beat-0 data was parked in beat0_q when a second read followed.
        align_in      = spans_q ? {mem_rdata, beat0_q}
                                : {{XLEN{1'b0}}, mem_rdata};
    end

    lsu_load_align #(
        .XLEN (XLEN)
    ) u_align (
        .data   (align_in),
        .off    (off_q),
        .funct3 (funct3_q),
        .result (align_out)
    );

    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        mem_en     = 1'b0;
        mem_we     = '0;
        mem_addr   = '0;
        mem_wdata  = '0;
        resp_valid = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    state_d = reject ? ST_RESP : ST_BEAT0;
            end
            ST_BEAT0: begin
                mem_en   = 1'b1;
                mem_addr = base_q;
                if (is_store_q) begin
                    mem_we    = we_full[NB-1:0];
                    mem_wdata = wd_full[XLEN-1:0];
                end
                if (spans_q)
                    state_d = ST_BEAT1;
                else
                    state_d = is_store_q ? ST_RESP : ST_CAPTURE;
            end
            ST_BEAT1: begin
                mem_en   = 1'b1;
                mem_addr = base_q + XLEN'(NB);
                if (is_store_q) begin
                    mem_we    = we_full[NB2-1:NB];
                    mem_wdata = wd_full[2*XLEN-1:XLEN];
                end
                state_d = is_store_q ? ST_RESP : ST_CAPTURE;
            end
            ST_CAPTURE: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready)
                    state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            is_store_q      <= 1'b0;
            funct3_q        <= '0;
            addr_q          <= '0;
            wdata_q         <= '0;
            beat0_q         <= '0;
            resp_data       <= '0;
            resp_misaligned <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                is_store_q      <= req_is_store;
                funct3_q        <= req_funct3;
                addr_q          <= req_addr;
                wdata_q         <= req_wdata;
                resp_data       <= '0;
                resp_misaligned <= reject;
            end
            if (state_q == ST_BEAT1 && !is_store_q)
                beat0_q <= mem_rdata;
            if (state_q == ST_CAPTURE)
                resp_data <= align_out;
        end
    end

endmodule

// File: tb/tb_lsu_misaligned_unit.sv
// Randomised and directed bench for lsu_misaligned_unit (XLEN=32),
// with one instance splitting spans and one rejecting misalignment.
module tb_lsu_misaligned_unit;
    import lsu_misaligned_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_req_valid, b_req_valid;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_ready;

    logic        a_req_ready, a_mem_en, a_resp_valid, a_resp_mis;
    logic [3:0]  a_mem_we;
    logic [31:0] a_mem_addr, a_mem_wdata, a_rdata, a_resp_data;
    logic        b_req_ready, b_mem_en, b_resp_valid, b_resp_mis;
    logic [3:0]  b_mem_we;
    logic [31:0] b_mem_addr, b_mem_wdata, b_rdata, b_resp_data;

    logic        sel;
    logic        cur_req_ready, cur_mem_en, cur_resp_valid, cur_resp_mis;
    logic [3:0]  cur_mem_we;
    logic [31:0] cur_mem_addr, cur_mem_wdata, cur_resp_data;

    int vectors = 0;
    int errors  = 0;

    logic [7:0] mbyte [logic [31:0]];
    logic [7:0] rbyte [logic [31:0]];

    always #5 clk = ~clk;

    lsu_misaligned_unit #(.XLEN(32), .MISALIGN_EN(1'b1)) dut_a (
        .clk(clk), .rst(rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_is_store(req_is_store), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_rdata),
        .resp_valid(a_resp_valid), .resp_ready(resp_ready),
        .resp_data(a_resp_data), .resp_misaligned(a_resp_mis)
    );

    lsu_misaligned_unit #(.XLEN(32), .MISALIGN_EN(1'b0)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_is_store(req_is_store), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_rdata),
        .resp_valid(b_resp_valid), .resp_ready(resp_ready),
        .resp_data(b_resp_data), .resp_misaligned(b_resp_mis)
    );

    always_comb begin
        cur_req_ready  = sel ? b_req_ready  : a_req_ready;
        cur_mem_en     = sel ? b_mem_en     : a_mem_en;
        cur_mem_we     = sel ? b_mem_we     : a_mem_we;
        cur_mem_addr   = sel ? b_mem_addr   : a_mem_addr;
        cur_mem_wdata  = sel ? b_mem_wdata  : a_mem_wdata;
        cur_resp_valid = sel ? b_resp_valid : a_resp_valid;
        cur_resp_data  = sel ? b_resp_data  : a_resp_data;
        cur_resp_mis   = sel ? b_resp_mis   : a_resp_mis;
    end

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    function automatic logic [7:0] get_m(input logic [31:0] a);
        return mbyte.exists(a) ? mbyte[a] : init_byte(a);
    endfunction

    function automatic logic [7:0] get_r(input logic [31:0] a);
        return rbyte.exists(a) ? rbyte[a] : init_byte(a);
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        for (int i = 0; i < 4; i++)
            w[8*i +: 8] = get_m(a + 32'(i));
        return w;
    endfunction

    // Byte-addressed memory behind both instances; reads return next cycle.
    always @(posedge clk) begin
        a_rdata <= $urandom;
        b_rdata <= $urandom;
        if (a_mem_en) begin
            for (int i = 0; i < 4; i++)
                if (a_mem_we[i]) mbyte[a_mem_addr + 32'(i)] = a_mem_wdata[8*i +: 8];
            if (a_mem_we == 4'b0) a_rdata <= mem_word(a_mem_addr);
        end
        if (b_mem_en) begin
            for (int i = 0; i < 4; i++)
                if (b_mem_we[i]) mbyte[b_mem_addr + 32'(i)] = b_mem_wdata[8*i +: 8];
            if (b_mem_we == 4'b0) b_rdata <= mem_word(b_mem_addr);
        end
    end

    task automatic preload(input logic [31:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            mbyte[a + 32'(i)] = w[8*i +: 8];
            rbyte[a + 32'(i)] = w[8*i +: 8];
        end
    endtask

    task automatic run_req(input bit nm, input bit st, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input int hold, input string tag);
        int sz, off, lat, nbeats, exp_lat, exp_beats;
        bit mis, spans, flag, got;
        logic [31:0] exp_data, base, w, a, lmask, got_data;
        logic [3:0] ewe;
        logic [31:0] ewd;
        logic [1:0] ln;
        sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        off = int'(addr[1:0]);
        mis = (addr % 32'(sz)) != 0;
        spans = (off + sz) > 4;
        flag = mis && nm;
        exp_beats = flag ? 0 : (spans ? 2 : 1);
        exp_lat = flag ? 1 : st ? (spans ? 3 : 2) : (spans ? 4 : 3);
        base = {addr[31:2], 2'b00};
        exp_data = 32'h0;
        if (!flag && !st) begin
            for (int i = 0; i < sz; i++)
                exp_data[8*i +: 8] = get_r(addr + 32'(i));
            if (!f3[2] && sz == 1) exp_data = {{24{exp_data[7]}}, exp_data[7:0]};
            if (!f3[2] && sz == 2) exp_data = {{16{exp_data[15]}}, exp_data[15:0]};
        end

        @(negedge clk);
        sel = nm;
        req_is_store = st;
        req_funct3 = f3;
        req_addr = addr;
        req_wdata = wd;
        if (nm) b_req_valid = 1'b1; else a_req_valid = 1'b1;
        #1;
        vectors++;
        if (cur_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s req_ready got=%b want=1", tag, cur_req_ready);
        end
        @(posedge clk);
        #1;
        a_req_valid = 1'b0;
        b_req_valid = 1'b0;

        lat = 0;
        nbeats = 0;
        got = 0;
        for (int k = 1; k <= 12 && !got; k++) begin
            @(negedge clk);
            lat = k;
            vectors++;
            if (cur_req_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s busy_ready cyc=%0d got=%b want=0", tag, k, cur_req_ready);
            end
            if (cur_mem_en === 1'b1) begin
                w = base + 32'(4 * nbeats);
                ewe = 4'b0;
                ewd = 32'h0;
                lmask = 32'h0;
                if (st) begin
                    for (int i = 0; i < sz; i++) begin
                        a = addr + 32'(i);
                        ln = a[1:0];
                        if ({a[31:2], 2'b00} == w) begin
                            ewe[ln] = 1'b1;
                            ewd[8*ln +: 8] = wd[8*i +: 8];
                            lmask[8*ln +: 8] = 8'hFF;
                        end
                    end
                end
                vectors++;
                if (cur_mem_addr !== w || cur_mem_we !== ewe ||
                    (cur_mem_wdata & lmask) !== ewd) begin
                    errors++;
                    $display("FAIL %s beat%0d addr=%h we=%b wd=%h want addr=%h we=%b wd=%h",
                             tag, nbeats, cur_mem_addr, cur_mem_we,
                             cur_mem_wdata & lmask, w, ewe, ewd);
                end
                nbeats++;
            end
            if (cur_resp_valid === 1'b1) got = 1;
        end

        vectors++;
        if (!got || lat != exp_lat) begin
            errors++;
            $display("FAIL %s latency got=%0d valid=%b want=%0d", tag, lat, got, exp_lat);
        end
        vectors++;
        if (nbeats != exp_beats) begin
            errors++;
            $display("FAIL %s beats got=%0d want=%0d", tag, nbeats, exp_beats);
        end
        vectors++;
        if (cur_resp_data !== exp_data || cur_resp_mis !== flag) begin
            errors++;
            $display("FAIL %s resp data=%h mis=%b want data=%h mis=%b",
                     tag, cur_resp_data, cur_resp_mis, exp_data, flag);
        end
        got_data = cur_resp_data;

        repeat (hold) begin
            @(negedge clk);
            vectors++;
            if (cur_resp_valid !== 1'b1 || cur_resp_data !== got_data ||
                cur_req_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s hold valid=%b data=%h ready=%b want 1 %h 0",
                         tag, cur_resp_valid, cur_resp_data, cur_req_ready, got_data);
            end
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        vectors++;
        if (cur_resp_valid !== 1'b0 || cur_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s after_hs valid=%b ready=%b want 0 1",
                     tag, cur_resp_valid, cur_req_ready);
        end

        if (st && !flag) begin
            for (int i = 0; i < sz; i++)
                rbyte[addr + 32'(i)] = wd[8*i +: 8];
            vectors++;
            for (int i = 0; i < 8; i++) begin
                a = base + 32'(i);
                if (get_m(a) !== get_r(a)) begin
                    errors++;
                    $display("FAIL %s store_mem @%h got=%h want=%h", tag, a, get_m(a), get_r(a));
                    break;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        vectors++;
        if ({a_req_ready, a_mem_en, a_mem_we, a_resp_valid, a_resp_mis} !== 8'b1000_0000) begin
            errors++;
            $display("FAIL reset_a_ctrl got=%b want=10000000",
                     {a_req_ready, a_mem_en, a_mem_we, a_resp_valid, a_resp_mis});
        end
        vectors++;
        if ({a_mem_addr, a_mem_wdata, a_resp_data} !== 96'h0) begin
            errors++;
            $display("FAIL reset_a_data got=%h want=0", {a_mem_addr, a_mem_wdata, a_resp_data});
        end
        vectors++;
        if ({b_req_ready, b_mem_en, b_resp_valid, b_resp_mis, b_resp_data} !== {4'b1000, 32'h0}) begin
            errors++;
            $display("FAIL reset_b got=%b %h want=1000 0",
                     {b_req_ready, b_mem_en, b_resp_valid, b_resp_mis}, b_resp_data);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        preload(32'h1000, 32'h12345678);
        run_req(0, 0, FNC_LB, 32'h1001, 32'h0, 0, "lb_1001");
        preload(32'h1000, 32'h89ABCDEF);
        preload(32'h1004, 32'h11223344);
        run_req(0, 0, FNC_LH, 32'h1003, 32'h0, 0, "lh_span");
        run_req(0, 1, FNC_SW, 32'h2002, 32'hDEADBEEF, 0, "sw_span");
        run_req(0, 1, FNC_SW, 32'hFFFFFFFE, 32'hDEADBEEF, 1, "sw_wrap");
        run_req(0, 0, FNC_LW, 32'hFFFFFFFE, 32'h0, 0, "lw_wrap");
        run_req(1, 0, FNC_LW, 32'h3001, 32'h0, 0, "nm_lw_rej");
        run_req(1, 1, FNC_SH, 32'h3003, 32'h1234, 0, "nm_sh_rej");
        preload(32'h0, 32'h89ABCDEF);
        run_req(0, 0, FNC_LHU, 32'h0002, 32'h0, 3, "lhu_hold");
        run_req(0, 0, FNC_LBU, 32'h0003, 32'h0, 0, "lbu");
        run_req(0, 1, FNC_SB, 32'h2005, 32'hA5A5A57E, 0, "sb");
    endtask

    task automatic test_reset_midop();
        preload(32'h1000, 32'h89ABCDEF);
        preload(32'h1004, 32'h11223344);
        preload(32'h0, 32'hCAFEF00D);
        @(negedge clk);
        sel = 1'b0;
        req_is_store = 1'b0;
        req_funct3 = FNC_LH;
        req_addr = 32'h1003;
        a_req_valid = 1'b1;
        @(posedge clk);
        #1;
        a_req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (a_mem_en !== 1'b1 || a_mem_addr !== 32'h1004) begin
            errors++;
            $display("FAIL midop_beat1 en=%b addr=%h want 1 00001004", a_mem_en, a_mem_addr);
        end
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if ({a_req_ready, a_mem_en, a_mem_we, a_resp_valid, a_resp_mis} !== 8'b1000_0000 ||
            {a_mem_addr, a_mem_wdata, a_resp_data} !== 96'h0) begin
            errors++;
            $display("FAIL midop_reset ctrl=%b addr=%h wd=%h data=%h want 10000000 0 0 0",
                     {a_req_ready, a_mem_en, a_mem_we, a_resp_valid, a_resp_mis},
                     a_mem_addr, a_mem_wdata, a_resp_data);
        end
        @(negedge clk);
        rst = 1'b0;
        run_req(0, 0, FNC_LW, 32'h0, 32'h0, 0, "lw_after_rst");
    endtask

    task automatic test_random(input int n);
        logic [2:0] lf [8];
        logic [2:0] f3;
        logic [31:0] addr;
        bit st, nm;
        lf = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
        for (int j = 0; j < n; j++) begin
            st = ($urandom_range(0, 2) == 0);
            nm = ($urandom_range(0, 3) == 0);
            f3 = st ? 3'($urandom_range(0, 2)) : lf[$urandom_range(0, 7)];
            if ($urandom_range(0, 7) == 0)
                addr = 32'hFFFFFFF8 + 32'($urandom_range(0, 7));
            else
                addr = 32'h4000 + 32'($urandom_range(0, 31));
            run_req(nm, st, f3, addr, $urandom, $urandom_range(0, 2), "rand");
        end
    endtask

    initial begin
        sel = 1'b0;
        a_req_valid = 1'b0;
        b_req_valid = 1'b0;
        req_is_store = 1'b0;
        req_funct3 = 3'b0;
        req_addr = 32'h0;
        req_wdata = 32'h0;
        resp_ready = 1'b0;
        test_reset();
        test_directed();
        test_reset_midop();
        test_random(60);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/lsu_misaligned_unit.md
Name: lsu_misaligned_unit

Overview:
Multi-cycle load/store unit and parametrised successor of the combinational partial-load extractor. Accepts one load or store request at a time from the memory stage, drives a word-wide synchronous memory port with byte enables, and returns aligned, sign- or zero-extended load data through a response handshake. It generalises to XLEN=32/64. When MISALIGN_EN=1, accesses that span two memory words are split into two beats. When MISALIGN_EN=0, misaligned accesses are flagged instead of issued.

Parameters:
XLEN, 32, data/address width; legal values 32 or 64; NB = XLEN/8 bytes per memory word.
MISALIGN_EN, 1, 1 = split word-spanning accesses into two beats; 0 = report misaligned, no memory access.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  unit can accept a request
req_is_store  in  1  1 = store, 0 = load
req_funct3  in  3  RISC-V load/store funct3 (FNC_LB..FNC_LWU)
req_addr  in  XLEN  byte address
req_wdata  in  XLEN  store data, right-justified
mem_en  out  1  memory access this cycle
mem_we  out  NB  byte write enables; 0 = read
mem_addr  out  XLEN  word-aligned address; low log2(NB) bits are 0
mem_wdata  out  XLEN  lane-aligned write data
mem_rdata  in  XLEN  read data, valid the cycle after a read beat
resp_valid  out  1  response available
resp_ready  in  1  consumer accepts response
resp_data  out  XLEN  extended load data; 0 for stores
resp_misaligned  out  1  misaligned access rejected (MISALIGN_EN=0 only)

Behaviour:
- Reset (async, immediate): state IDLE. req_ready=1. mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0. resp_valid=0, resp_data=0, resp_misaligned=0. Any in-flight read data is discarded.
- States: IDLE, BEAT0, BEAT1, CAPTURE, RESP. req_ready=1 only in IDLE; only one request is outstanding at a time.
- Accept on req_valid&&req_ready in cycle T. Register the request, then compute:
  - size = 1<<funct3[1:0]
  - off = addr[log2(NB)-1:0]
  - misaligned = addr mod size != 0
  - spans = off+size > NB
- funct3 011 or 110 with XLEN=32, and funct3 111: treated as full-XLEN unsigned access (pass-through).
- misaligned && !MISALIGN_EN: go IDLE->RESP, no mem_en. resp_misaligned=1, resp_data=0, resp_valid at T+1.
- BEAT0 (T+1): mem_en=1, mem_addr = addr with low bits cleared.
  - Stores: mem_wdata = wdata << 8*off; mem_we = ((1<<size)-1) << off, truncated to NB.
  - Next state: BEAT1 if spans, else CAPTURE for loads, RESP for stores.
- BEAT1 (T+2): mem_en=1, mem_addr = BEAT0 addr + NB, modulo 2^XLEN (0xFFFFFFFC wraps to 0).
  - Stores: remaining bytes shifted down, remaining enables in low lanes.
  - Loads: capture beat-0 mem_rdata. Next state: CAPTURE for loads, RESP for stores.
- CAPTURE: mem_en=0. Form {beat1, beat0} (2*XLEN wide), shift right by 8*off, keep size bytes. Sign-extend if funct3[2]=0, else zero-extend. Register into resp_data.
- Latency to resp_valid:
  - aligned load: T+3
  - spanning load: T+4
  - aligned store: T+2
  - spanning store: T+3
- RESP: resp_valid=1; resp_data and resp_misaligned held stable until resp_ready. On the handshake cycle go to IDLE; the next request can be accepted one cycle later.
- mem_en=0 and mem_we=0 in every state except BEAT0/BEAT1.
- Async rst mid-operation (any state): immediate return to reset values. A partially written spanning store is not rolled back.

Decomposition:
- Shared package/header (extends opcode.vh):
  - FNC_LB..FNC_LWU, FNC_SB..FNC_SD constants
  - state encoding localparams
  - NB and size-decode function
- One sub-module: lsu_load_align — combinational; inputs {beat1, beat0}, off, funct3; output extended XLEN result. It is the generalised partial-load extractor and is unit-tested separately.

Test Plan:
1. XLEN=32, LB at 0x1001, word@0x1000=0x12345678 -> one read at 0x1000; resp_data=0x00000056 at T+3.
2. LH at 0x1003, MISALIGN_EN=1, word@0x1000=0x89ABCDEF, word@0x1004=0x11223344 -> reads 0x1000 then 0x1004; resp_data=0x00004489 at T+4.
3. SW 0xDEADBEEF at 0x2002 -> beat0: addr 0x2000, we=1100, wdata[31:16]=0xBEEF; beat1: addr 0x2004, we=0011, wdata[15:0]=0xDEAD; resp_valid at T+3. Repeat at 0xFFFFFFFE -> beat1 addr 0x00000000.
4. MISALIGN_EN=0, LW at 0x3001 -> mem_en never asserted; resp_misaligned=1, resp_data=0 at T+1.
5. LHU at 0x0002, word=0x89ABCDEF; hold resp_ready=0 for 3 cycles -> resp_valid and resp_data=0x000089AB stable, req_ready=0 throughout; IDLE after the handshake.
6. Assert rst asynchronously during BEAT1 of a spanning load -> all outputs at reset values before the next edge; a following LW at 0x0 returns the correct word at T+3.
